// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes (sticky illegal flag).
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  // state      | meaning
  // S_FETCH    | read instruction at PC, PC <= PC + 4 when memory is ready
  // S_DECODE   | compute branch/jump target OldPC + imm
  // S_MEMADR   | compute load/store address rs1 + imm
  // S_MEMREAD  | load data access at ALUOut
  // S_MEMWRITE | store data access at ALUOut
  // S_MEMWB    | write loaded data to rd
  // S_EXECUTER | register-register ALU operation
  // S_EXECUTEI | register-immediate ALU operation
  // S_ALUWB    | write ALUOut to rd
  // S_BEQ      | compare rs1/rs2, take branch on zero
  // S_JAL      | PC <= target, ALU forms OldPC + 4 for the link
  // S_TRAP     | unknown opcode seen; frozen until reset (trap build only)

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } aluop_t;

  state_t state_q;
  state_t state_d;
  aluop_t aluop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    aluop     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALU_FUNCT;
      end
      S_ALUWB:  regwrite = 1'b1;
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALU_SUB;
        pcwrite = zero;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate type follows the opcode in every state so the extender is always ready.
  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  always_comb begin
    case (aluop)
      ALU_ADD: alucontrol = 3'b000;
      ALU_SUB: alucontrol = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_DECODE && state_d == S_TRAP) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases then random instruction streams
// compared cycle by cycle against a per-instruction step-list model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adrsrc(adrsrc),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .memwrite(memwrite),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_MWB, P_ER, P_EI, P_AWB, P_BEQ, P_JAL, P_TRAP} phase_t;
  typedef enum int {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_UNK} cls_t;

  int   checks = 0;
  int   fails  = 0;
  int   icount = 0;
  cls_t cur_cls = C_LW;
  logic ill = 1'b0;

  function automatic logic [6:0] op_of(input cls_t c);
    case (c)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic string pname(input phase_t p);
    case (p)
      P_F: return "fetch";     P_D: return "decode";    P_MA: return "memadr";
      P_MR: return "memread";  P_MW: return "memwrite"; P_MWB: return "memwb";
      P_ER: return "executer"; P_EI: return "executei"; P_AWB: return "aluwb";
      P_BEQ: return "beq";     P_JAL: return "jal";     default: return "trap";
    endcase
  endfunction

  // Arithmetic operation an R/I instruction asks for, by instruction meaning.
  function automatic logic [2:0] funct_op();
    if (funct3 == 3'b000) return (cur_cls == C_R && funct7b5) ? 3'b001 : 3'b000;
    if (funct3 == 3'b010) return 3'b101;
    if (funct3 == 3'b110) return 3'b011;
    if (funct3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [17:0] expect_out(input phase_t p, input logic rdy);
    logic mreq, asrc, irw, pcw, rw, mw;
    logic [1:0] imm, sa, sb, rs;
    logic [2:0] alu;
    {mreq, asrc, irw, pcw, rw, mw} = '0;
    {sa, sb, rs} = '0;
    alu = 3'b000;
    case (cur_cls)
      C_SW:    imm = 2'b01;
      C_BEQ:   imm = 2'b10;
      C_JAL:   imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (p)
      P_F:   begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_D:   begin sa = 2'b01; sb = 2'b01; end
      P_MA:  begin sa = 2'b10; sb = 2'b01; end
      P_MR:  begin mreq = 1; asrc = 1; end
      P_MW:  begin mreq = 1; asrc = 1; mw = 1; end
      P_MWB: begin rs = 2'b01; rw = 1; end
      P_ER:  begin sa = 2'b10; alu = funct_op(); end
      P_EI:  begin sa = 2'b10; sb = 2'b01; alu = funct_op(); end
      P_AWB: rw = 1;
      P_BEQ: begin sa = 2'b10; alu = 3'b001; pcw = zero; end
      P_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {mreq, asrc, irw, pcw, rw, mw, imm, sa, sb, rs, alu, ill};
  endfunction

  task automatic step(input phase_t p, input logic rdy);
    logic [17:0] exp_v, obs_v;
    mem_ready = rdy;
    if (p == P_TRAP) ill = 1'b1;
    #2;
    exp_v = expect_out(p, rdy);
    obs_v = {mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite, immsrc,
             alusrca, alusrcb, resultsrc, alucontrol, illegal};
    checks++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s instr %0d: observed %05h expected %05h", pname(p), icount, obs_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  // One whole instruction; fst/mst = cycles mem_ready is held low in fetch / data access.
  task automatic run_instr(input cls_t c, input logic [2:0] f3, input logic f7,
                           input logic z, input int fst, input int mst);
    phase_t q[$];
    int n;
    cur_cls = c; op = op_of(c); funct3 = f3; funct7b5 = f7; zero = z;
    icount++;
    q = '{P_F, P_D};
    case (c)
      C_LW:  q = {q, P_MA, P_MR, P_MWB};
      C_SW:  q = {q, P_MA, P_MW};
      C_R:   q = {q, P_ER, P_AWB};
      C_I:   q = {q, P_EI, P_AWB};
      C_BEQ: q = {q, P_BEQ};
      C_JAL: q = {q, P_JAL, P_AWB};
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        q = {q, P_TRAP, P_TRAP, P_TRAP, P_TRAP};
`endif
      end
    endcase
    foreach (q[i]) begin
      if (q[i] == P_F || q[i] == P_MR || q[i] == P_MW) begin
        n = (q[i] == P_F) ? fst : mst;
        for (int k = 0; k <= n; k++) step(q[i], k == n);
      end else begin
        step(q[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; op = op_of(C_LW);
    funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    // In reset: fetch outputs, strobes follow mem_ready.
    step(P_F, 1'b1);
    step(P_F, 1'b0);
    reset_n = 1'b1;

    run_instr(C_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(C_R,  3'b000, 1'b1, 1'b0, 3, 0);
    run_instr(C_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(C_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(C_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(C_SW,  3'b010, 1'b0, 1'b0, 1, 2);
    run_instr(C_LW,  3'b010, 1'b0, 1'b0, 2, 3);
    run_instr(C_I,   3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(C_R,   3'b111, 1'b0, 1'b0, 0, 0);
    run_instr(C_I,   3'b110, 1'b0, 1'b0, 0, 0);

    // Reset in the middle of a load: back to fetch at once, no writeback.
    cur_cls = C_LW; op = op_of(C_LW); icount++;
    step(P_F, 1'b1);
    step(P_D, 1'b1);
    step(P_MA, 1'b1);
    reset_n = 1'b0;
    ill = 1'b0;
    step(P_F, 1'b1);
    reset_n = 1'b1;
    run_instr(C_R, 3'b010, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      run_instr(cls_t'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
`else
      run_instr(cls_t'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
`endif
    end

    // Unknown opcode: traps in the trap build, no-op otherwise.
    run_instr(C_UNK, 3'b000, 1'b0, 1'b0, 0, 0);
    reset_n = 1'b0;
    ill = 1'b0;
    cur_cls = C_LW; op = op_of(C_LW);
    step(P_F, 1'b1);
    reset_n = 1'b1;
    run_instr(C_JAL, 3'b000, 1'b0, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
